// File: rtl/mother_base_health_object.sv
`default_nettype none
// ============================================================================
// Module      : mother_base_health_object
// Description : On-screen mother base sprite with a hit counter, an
//               invulnerable flash period after each hit and a destroyed
//               state. The pixel outputs are registered, one clk after
//               pixelX/pixelY.
// Revision    : 1.0 - initial release
// ============================================================================
module mother_base_health_object #(
    parameter int          OBJECT_WIDTH_X  = 100,
    parameter int          OBJECT_HEIGHT_Y = 100,
    parameter int          topLeftX        = 255,
    parameter int          topLeftY        = 446,
    parameter logic [7:0]  OBJECT_COLOR    = 8'h5B,
    parameter logic [7:0]  HIT_COLOR       = 8'hE0,
    parameter logic [7:0]  DEAD_COLOR      = 8'h49,
    parameter int          MAX_HITS        = 3,
    parameter int          FLASH_FRAMES    = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        hit,
    input  logic        revive,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        drawingRequest,
    output logic [7:0]  RGBout,
    output logic [3:0]  hitsLeft,
    output logic        destroyed
);

    // State encoding
    localparam logic [1:0]  c_ST_ALIVE     = 2'd0;
    localparam logic [1:0]  c_ST_FLASH     = 2'd1;
    localparam logic [1:0]  c_ST_DEAD      = 2'd2;

    // Bounding box, one bit wider than the pixel bus so the exclusive
    // right/bottom edge can never wrap.
    localparam logic [11:0] c_X_START      = 12'(topLeftX);
    localparam logic [11:0] c_X_END        = 12'(topLeftX + OBJECT_WIDTH_X);
    localparam logic [11:0] c_Y_START      = 12'(topLeftY);
    localparam logic [11:0] c_Y_END        = 12'(topLeftY + OBJECT_HEIGHT_Y);

    localparam logic [3:0]  c_MAX_HITS     = 4'(MAX_HITS);
    localparam logic [7:0]  c_FLASH_FRAMES = 8'(FLASH_FRAMES);
    localparam logic [7:0]  c_TRANSPARENT  = 8'hFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_hits_left;
    logic [3:0]  w_hits_nxt;
    logic [7:0]  r_flash_cnt;
    logic [7:0]  w_flash_nxt;
    logic        r_destroyed;

    logic [10:0] r_offset_x;
    logic [10:0] r_offset_y;
    logic        r_draw;
    logic [7:0]  r_rgb;

    logic [11:0] w_px;
    logic [11:0] w_py;
    logic        w_inside;
    logic [7:0]  w_color;

    assign w_px     = {1'b0, pixelX};
    assign w_py     = {1'b0, pixelY};
    assign w_inside = (w_px >= c_X_START) && (w_px < c_X_END) &&
                      (w_py >= c_Y_START) && (w_py < c_Y_END);

    // Sprite colour from the current (pre-update) health state
    always_comb begin
        w_color = OBJECT_COLOR;
        case (r_state)
            c_ST_FLASH: w_color = r_flash_cnt[0] ? HIT_COLOR : OBJECT_COLOR;
            c_ST_DEAD:  w_color = DEAD_COLOR;
            default:    w_color = OBJECT_COLOR;
        endcase
    end

    // Next health state; revive overrides everything, hits only count in ALIVE
    always_comb begin
        w_state_nxt = r_state;
        w_hits_nxt  = r_hits_left;
        w_flash_nxt = r_flash_cnt;
        if (revive) begin
            w_state_nxt = c_ST_ALIVE;
            w_hits_nxt  = c_MAX_HITS;
            w_flash_nxt = 8'd0;
        end else begin
            case (r_state)
                c_ST_ALIVE: begin
                    // A simultaneous startOfFrame is ignored: the flash
                    // counter is loaded, not decremented, on the hit cycle.
                    if (hit) begin
                        if (r_hits_left <= 4'd1) begin
                            w_hits_nxt  = 4'd0;
                            w_state_nxt = c_ST_DEAD;
                            w_flash_nxt = 8'd0;
                        end else begin
                            w_hits_nxt  = r_hits_left - 4'd1;
                            w_state_nxt = c_ST_FLASH;
                            w_flash_nxt = c_FLASH_FRAMES;
                        end
                    end
                end
                c_ST_FLASH: begin
                    if (startOfFrame) begin
                        if (r_flash_cnt <= 8'd1) begin
                            w_flash_nxt = 8'd0;
                            w_state_nxt = c_ST_ALIVE;
                        end else begin
                            w_flash_nxt = r_flash_cnt - 8'd1;
                        end
                    end
                end
                c_ST_DEAD: begin
                    w_hits_nxt  = 4'd0;
                    w_flash_nxt = 8'd0;
                end
                default: begin
                    w_state_nxt = c_ST_ALIVE;
                    w_hits_nxt  = c_MAX_HITS;
                    w_flash_nxt = 8'd0;
                end
            endcase
        end
    end

    // Health state registers and the registered destroyed flag
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= c_ST_ALIVE;
            r_hits_left <= c_MAX_HITS;
            r_flash_cnt <= 8'd0;
            r_destroyed <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hits_left <= w_hits_nxt;
            r_flash_cnt <= w_flash_nxt;
            r_destroyed <= (w_state_nxt == c_ST_DEAD);
        end
    end

    // Registered pixel path: box test, offsets and colour
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_draw     <= 1'b0;
            r_rgb      <= 8'h00;
            r_offset_x <= 11'd0;
            r_offset_y <= 11'd0;
        end else if (w_inside) begin
            r_draw     <= 1'b1;
            r_rgb      <= w_color;
            r_offset_x <= pixelX - c_X_START[10:0];
            r_offset_y <= pixelY - c_Y_START[10:0];
        end else begin
            r_draw     <= 1'b0;
            r_rgb      <= c_TRANSPARENT;
            r_offset_x <= 11'd0;
            r_offset_y <= 11'd0;
        end
    end

    assign offsetX        = r_offset_x;
    assign offsetY        = r_offset_y;
    assign drawingRequest = r_draw;
    assign RGBout         = r_rgb;
    assign hitsLeft       = r_hits_left;
    assign destroyed      = r_destroyed;

endmodule
`default_nettype wire

// File: tb/tb_mother_base_health_object.sv
`default_nettype none
// ============================================================================
// Module      : tb_mother_base_health_object
// Description : Self-checking bench for mother_base_health_object: pixel
//               vector table, hand-written health sequences and a random
//               run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mother_base_health_object;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = 11'd0;
    logic [10:0] pixelY = 11'd0;
    logic        startOfFrame = 1'b0;
    logic        hit = 1'b0;
    logic        revive = 1'b0;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [3:0]  hitsLeft;
    logic        destroyed;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: hits remaining, dead flag, frames of flash left
    int m_hits;
    bit m_dead;
    int m_flash;

    mother_base_health_object dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .hit            (hit),
        .revive         (revive),
        .offsetX        (offsetX),
        .offsetY        (offsetY),
        .drawingRequest (drawingRequest),
        .RGBout         (RGBout),
        .hitsLeft       (hitsLeft),
        .destroyed      (destroyed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         x;
        int         y;
        logic       draw;
        logic [7:0] rgb;
        int         ox;
        int         oy;
    } pix_vec_t;

    pix_vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_hits  = 3;
        m_dead  = 1'b0;
        m_flash = 0;
    endfunction

    function automatic void model_apply(input bit h, input bit s, input bit r);
        if (r) begin
            model_reset();
        end else if (m_dead) begin
            // destroyed base ignores everything but revive
        end else if (m_flash > 0) begin
            if (s) m_flash = m_flash - 1;
        end else if (h) begin
            m_hits = m_hits - 1;
            if (m_hits == 0) m_dead = 1'b1;
            else             m_flash = 8;
        end
    endfunction

    function automatic int model_color();
        if (m_dead)               return 'h49;
        if ((m_flash % 2) == 1)   return 'hE0;
        return 'h5B;
    endfunction

    // One clock with the given pulses; outputs are settled on return
    task automatic cycle(input bit h, input bit s, input bit r);
        hit          = h;
        startOfFrame = s;
        revive       = r;
        @(posedge clk);
        #1;
        hit          = 1'b0;
        startOfFrame = 1'b0;
        revive       = 1'b0;
        model_apply(h, s, r);
    endtask

    task automatic sofs(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    // Idle clock, then check the colour of the held inside pixel
    task automatic idle_rgb(input string name, input int exp);
        cycle(1'b0, 1'b0, 1'b0);
        chk(name, int'(RGBout), exp);
    endtask

    initial begin
        vecs[0] = '{255, 446, 1'b1, 8'h5B,  0,  0};
        vecs[1] = '{355, 446, 1'b0, 8'hFF,  0,  0};
        vecs[2] = '{354, 545, 1'b1, 8'h5B, 99, 99};
        vecs[3] = '{254, 500, 1'b0, 8'hFF,  0,  0};
        vecs[4] = '{300, 545, 1'b1, 8'h5B, 45, 99};
        vecs[5] = '{300, 546, 1'b0, 8'hFF,  0,  0};
        vecs[6] = '{300, 445, 1'b0, 8'hFF,  0,  0};
        vecs[7] = '{  0,   0, 1'b0, 8'hFF,  0,  0};

        // Reset values
        model_reset();
        pixelX = 11'd300;
        pixelY = 11'd500;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_rgb",       int'(RGBout), 'h00);
        chk("reset_draw",      int'(drawingRequest), 0);
        chk("reset_offx",      int'(offsetX), 0);
        chk("reset_offy",      int'(offsetY), 0);
        chk("reset_hits",      int'(hitsLeft), 3);
        chk("reset_destroyed", int'(destroyed), 0);
        resetN = 1'b1;

        // Pixel table
        for (int i = 0; i < 8; i++) begin
            pixelX = 11'(vecs[i].x);
            pixelY = 11'(vecs[i].y);
            cycle(1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_draw", i), int'(drawingRequest), int'(vecs[i].draw));
            chk($sformatf("vec%0d_rgb", i),  int'(RGBout), int'(vecs[i].rgb));
            chk($sformatf("vec%0d_offx", i), int'(offsetX), vecs[i].ox);
            chk($sformatf("vec%0d_offy", i), int'(offsetY), vecs[i].oy);
        end

        pixelX = 11'd300;
        pixelY = 11'd500;

        // Hit, flash with ignored second hit, recovery after 8 frames
        cycle(1'b1, 1'b0, 1'b0);
        chk("hit1_hits", int'(hitsLeft), 2);
        idle_rgb("flash8_rgb", 'h5B);
        sofs(2);
        cycle(1'b1, 1'b0, 1'b0);
        chk("flash_hit_ignored", int'(hitsLeft), 2);
        sofs(1);
        idle_rgb("flash5_rgb", 'hE0);
        sofs(4);
        idle_rgb("flash1_rgb", 'hE0);
        sofs(1);
        idle_rgb("alive_again_rgb", 'h5B);
        chk("alive_again_hits", int'(hitsLeft), 2);
        cycle(1'b1, 1'b0, 1'b0);
        chk("hit_after_flash", int'(hitsLeft), 1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("revive_hits", int'(hitsLeft), 3);

        // Hit and startOfFrame together: counter loaded, not decremented
        cycle(1'b1, 1'b1, 1'b0);
        chk("hit_sof_hits", int'(hitsLeft), 2);
        idle_rgb("hit_sof_rgb", 'h5B);
        sofs(7);
        idle_rgb("hit_sof_last_rgb", 'hE0);
        sofs(1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("hit_sof_recover", int'(hitsLeft), 1);
        cycle(1'b0, 1'b0, 1'b1);

        // Three hits to destruction
        for (int k = 1; k <= 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (k < 3) sofs(8);
        end
        chk("dead_hits", int'(hitsLeft), 0);
        chk("dead_flag", int'(destroyed), 1);
        idle_rgb("dead_rgb", 'h49);
        cycle(1'b1, 1'b1, 1'b0);
        chk("dead_hit_hits", int'(hitsLeft), 0);
        chk("dead_hit_flag", int'(destroyed), 1);
        idle_rgb("dead_hold_rgb", 'h49);

        // Revive wins over simultaneous hit
        cycle(1'b1, 1'b0, 1'b1);
        chk("revive_hit_hits", int'(hitsLeft), 3);
        chk("revive_hit_flag", int'(destroyed), 0);
        idle_rgb("revive_hit_rgb", 'h5B);

        // Asynchronous reset mid-flash (flash counter at 5)
        cycle(1'b1, 1'b0, 1'b0);
        sofs(3);
        idle_rgb("pre_reset_rgb", 'hE0);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_rst_rgb",  int'(RGBout), 'h00);
        chk("async_rst_draw", int'(drawingRequest), 0);
        chk("async_rst_offx", int'(offsetX), 0);
        chk("async_rst_hits", int'(hitsLeft), 3);
        chk("async_rst_dead", int'(destroyed), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
        idle_rgb("post_rst_rgb", 'h5B);
        cycle(1'b1, 1'b0, 1'b0);
        chk("post_rst_hit", int'(hitsLeft), 2);

        // Randomized run against the model
        cycle(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            int  x;
            int  y;
            bit  h;
            bit  s;
            bit  r;
            bit  ins;
            int  ecol;
            x    = int'($urandom_range(200, 420));
            y    = int'($urandom_range(400, 600));
            h    = ($urandom % 4) == 0;
            s    = ($urandom % 3) == 0;
            r    = ($urandom % 64) == 0;
            ins  = (x >= 255) && (x < 355) && (y >= 446) && (y < 546);
            ecol = model_color();
            pixelX = 11'(x);
            pixelY = 11'(y);
            cycle(h, s, r);
            chk("rnd_draw", int'(drawingRequest), int'(ins));
            chk("rnd_rgb",  int'(RGBout), ins ? ecol : 'hFF);
            chk("rnd_offx", int'(offsetX), ins ? x - 255 : 0);
            chk("rnd_offy", int'(offsetY), ins ? y - 446 : 0);
            chk("rnd_hits", int'(hitsLeft), m_hits);
            chk("rnd_dead", int'(destroyed), int'(m_dead));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mother_base_health_object.md
MOTHER_BASE_HEALTH_OBJECT -- requirements
Module: mother_base_health_object

Interface
REQ-001 Parameter OBJECT_WIDTH_X, default 100, object width in pixels.
REQ-002 Parameter OBJECT_HEIGHT_Y, default 100, object height in pixels.
REQ-003 Parameter topLeftX, default 255, left edge X coordinate.
REQ-004 Parameter topLeftY, default 446, top edge Y coordinate.
REQ-005 Parameter OBJECT_COLOR, default 8'h5B, healthy colour.
REQ-006 Parameter HIT_COLOR, default 8'hE0, flash colour.
REQ-007 Parameter DEAD_COLOR, default 8'h49, destroyed colour.
REQ-008 Parameter MAX_HITS, default 3, legal range 1..15, hits needed to destroy.
REQ-009 Parameter FLASH_FRAMES, default 8, legal range 1..255, invulnerable flash length in frames.
REQ-010 Port clk  input  1  system clock; sole clock.
REQ-011 Port resetN  input  1  asynchronous, active-low reset.
REQ-012 Port pixelX  input  11  current VGA pixel X.
REQ-013 Port pixelY  input  11  current VGA pixel Y.
REQ-014 Port startOfFrame  input  1  one-cycle pulse per frame.
REQ-015 Port hit  input  1  one-cycle pulse: projectile struck base.
REQ-016 Port revive  input  1  one-cycle pulse: restore base (new level).
REQ-017 Port offsetX  output  11  pixelX minus topLeftX inside box, else 0.
REQ-018 Port offsetY  output  11  pixelY minus topLeftY inside box, else 0.
REQ-019 Port drawingRequest  output  1  pixel belongs to object.
REQ-020 Port RGBout  output  8  object colour, 8'hFF when transparent.
REQ-021 Port hitsLeft  output  4  remaining hits.
REQ-022 Port destroyed  output  1  high while state is DEAD.

Function
REQ-023 Inside = pixelX >= topLeftX, pixelX < topLeftX+OBJECT_WIDTH_X, pixelY >= topLeftY, pixelY < topLeftY+OBJECT_HEIGHT_Y; right/bottom edges exclusive.
REQ-024 offsetX, offsetY, drawingRequest, RGBout registered: exactly 1 clk latency from pixelX/pixelY.
REQ-025 Outside: drawingRequest 0, RGBout 8'hFF, offsets 0.
REQ-026 Inside: drawingRequest 1, offsets computed; RGBout per state (REQ-031).
REQ-027 FSM states ALIVE, FLASH, DEAD; 4-bit hitsLeft counter; 8-bit flashCnt counter.
REQ-028 ALIVE + hit: hitsLeft decrements; result 0 -> DEAD; else -> FLASH, flashCnt loaded with FLASH_FRAMES.
REQ-029 FLASH: hit ignored (invulnerable); each startOfFrame decrements flashCnt; startOfFrame with flashCnt==1 -> ALIVE, flashCnt 0.
REQ-030 DEAD: hit ignored; hitsLeft stays 0; state held until revive or reset.
REQ-031 RGBout inside: ALIVE OBJECT_COLOR; FLASH HIT_COLOR when flashCnt[0]==1, else OBJECT_COLOR; DEAD DEAD_COLOR.
REQ-032 revive in any state: next cycle ALIVE, hitsLeft=MAX_HITS, flashCnt 0; revive wins over simultaneous hit.
REQ-033 ALIVE, hit and startOfFrame same cycle: hit processed; flashCnt loaded, not decremented.
REQ-034 State/counter updates take effect next clk; pixel output in that cycle uses pre-update state.
REQ-035 hitsLeft never underflows; destroyed = (state==DEAD), registered.

Reset
REQ-036 resetN low, asynchronous: state ALIVE, hitsLeft=MAX_HITS, flashCnt 0, RGBout 8'h00, drawingRequest 0, offsets 0, destroyed 0.
REQ-037 Reset mid-FLASH or in DEAD aborts immediately to REQ-036 values; first clk after release behaves as ALIVE.

Verification
REQ-038 Pixel (255,446) -> next clk drawingRequest 1, RGBout 8'h5B, offsets (0,0); (355,446) -> drawingRequest 0, RGBout 8'hFF, offsets (0,0).
REQ-039 Pixel (354,545) -> offsets (99,99); (254,500) -> drawingRequest 0.
REQ-040 One hit -> hitsLeft 2, FLASH; second hit 2 frames later ignored (hitsLeft 2); after 8 startOfFrame pulses -> ALIVE, inside pixel 8'h5B.
REQ-041 Three hits, each after flash ends -> hitsLeft 0, destroyed 1, inside pixel 8'h49; further hit -> no change.
REQ-042 DEAD, hit and revive same cycle -> ALIVE, hitsLeft 3, destroyed 0.
REQ-043 resetN low mid-FLASH (flashCnt 5) -> outputs immediately REQ-036 values; hitsLeft 3.
